trigger_sequencer: RTL

Acquisition-cycle controller that sequences the `TriggerControl` comparator front end. It arms the trigger, detects the trigger event, and counts a programmable post-trigger capture window. It then hands the buffer to readout, pulses the comparator reset, and applies a hold-off before re-arming (auto mode) or returning to idle. It sits between the host command/register block and `TriggerControl`, and gates the ADC capture FIFO write enable.

---
 rtl/trigger_seq_pkg.sv | 27 ++
 rtl/seq_down_counter.sv | 30 +++
 rtl/trigger_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/trigger_seq_pkg.sv
// Shared types and defaults for the trigger_sequencer acquisition controller.
package trigger_seq_pkg;

  localparam int POST_W_DEF          = 16;
  localparam int HOLDOFF_W_DEF       = 8;
  localparam int TIMEOUT_W_DEF       = 20;
  localparam int COMP_RST_CYCLES_DEF = 4;
  localparam int TRIG_COUNT_W        = 16;

  // Encodings are visible on state_out, so they are fixed explicitly.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_POST     = 3'd2,
    S_READOUT  = 3'd3,
    S_COMP_RST = 3'd4,
    S_HOLDOFF  = 3'd5
  } seq_state_t;

  // Width needed by a counter that is shared between several windows.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero; flags report zero and one.
module seq_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] count;

  // Load has priority over counting; the count never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign one  = (count == W'(1));

endmodule

// File: rtl/trigger_sequencer.sv
// Acquisition-cycle controller for the TriggerControl comparator front end.
// Optional feature: define TRIG_TIMEOUT_EN to add the auto-trigger timeout.
//
// Handshakes: arm_req, disarm, force_trig and readout_ack are single-cycle
// pulses sampled on the rising clock edge. readout_req stays high for the
// whole READOUT state and drops on the edge after readout_ack is sampled;
// an ack seen outside READOUT is ignored.
module trigger_sequencer
  import trigger_seq_pkg::*;
#(
  parameter int POST_W          = POST_W_DEF,
  parameter int HOLDOFF_W       = HOLDOFF_W_DEF,
  parameter int COMP_RST_CYCLES = COMP_RST_CYCLES_DEF,
  parameter int TIMEOUT_W       = TIMEOUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    module_reset_n,
  input  logic                    arm_req,
  input  logic                    disarm,
  input  logic                    auto_rearm,
  input  logic                    force_trig,
  input  logic [POST_W-1:0]       post_trig_len,
  input  logic [HOLDOFF_W-1:0]    holdoff_len,
  input  logic [TIMEOUT_W-1:0]    timeout_len,
  input  logic                    triggered_in,
  output logic                    armed_out,
  output logic                    manual_reset_out,
  output logic                    capture_en,
  output logic                    readout_req,
  input  logic                    readout_ack,
  output logic                    busy,
  output logic                    timed_out,
  output logic [TRIG_COUNT_W-1:0] trig_count,
  output logic [2:0]              state_out
);

  localparam int WIN_W = max3(POST_W, HOLDOFF_W, $clog2(COMP_RST_CYCLES + 1));

  seq_state_t           state, next_state;
  logic [POST_W-1:0]    post_len_q;
  logic [HOLDOFF_W-1:0] holdoff_len_q;
  logic                 trig_q, trig_prev;
  logic                 edge_trig, real_trig, timeout_fire;
  logic                 win_load, win_zero, win_one;
  logic [WIN_W-1:0]     win_val;
  logic                 latch_lens, count_inc;

  // trig_prev is forced high outside ARMED so a level that is already high
  // on entry cannot look like a rising edge.
  assign edge_trig = (state == S_ARMED) && trig_q && !trig_prev;
  assign real_trig = force_trig || edge_trig;

  // One window counter serves POST, COMP_RST and HOLDOFF; reloaded per state.
  seq_down_counter #(.W(WIN_W)) u_win (
    .clk      (clk),
    .rst_n    (module_reset_n),
    .load     (win_load),
    .en       (1'b1),
    .load_val (win_val),
    .zero     (win_zero),
    .one      (win_one)
  );

  // Next-state and window-load decode; disarm overrides everything.
  always_comb begin
    next_state = state;
    win_load   = 1'b0;
    win_val    = '0;
    latch_lens = 1'b0;
    count_inc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arm_req) begin
          next_state = S_ARMED;
          latch_lens = 1'b1;
        end
      end
      S_ARMED: begin
        if (real_trig || timeout_fire) begin
          if (post_len_q == '0) begin
            next_state = S_READOUT;
          end else begin
            next_state = S_POST;
            win_load   = 1'b1;
            win_val    = WIN_W'(post_len_q);
          end
        end
      end
      S_POST: begin
        // win_zero is a guard so the window can never stall.
        if (win_one || win_zero) next_state = S_READOUT;
      end
      S_READOUT: begin
        if (readout_ack) begin
          next_state = S_COMP_RST;
          win_load   = 1'b1;
          win_val    = WIN_W'(COMP_RST_CYCLES);
          count_inc  = 1'b1;
        end
      end
      S_COMP_RST: begin
        if (win_one || win_zero) begin
          if (holdoff_len_q != '0) begin
            next_state = S_HOLDOFF;
            win_load   = 1'b1;
            win_val    = WIN_W'(holdoff_len_q);
          end else begin
            next_state = auto_rearm ? S_ARMED : S_IDLE;
          end
        end
      end
      S_HOLDOFF: begin
        if (win_one || win_zero) next_state = auto_rearm ? S_ARMED : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (disarm) begin
      next_state = S_IDLE;
      win_load   = 1'b0;
      latch_lens = 1'b0;
      count_inc  = 1'b0;
    end
  end

  // State, trigger edge detector, latched lengths and cycle counter.
  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n) begin
      state         <= S_IDLE;
      trig_q        <= 1'b0;
      trig_prev     <= 1'b1;
      post_len_q    <= '0;
      holdoff_len_q <= '0;
      trig_count    <= '0;
    end else begin
      state     <= next_state;
      trig_q    <= triggered_in;
      trig_prev <= (state == S_ARMED) ? trig_q : 1'b1;
      if (latch_lens) begin
        post_len_q    <= post_trig_len;
        holdoff_len_q <= holdoff_len;
      end
      if (count_inc) trig_count <= trig_count + 1'b1;
    end
  end

  // Outputs are registered decodes of the state being entered.
  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n) begin
      armed_out        <= 1'b0;
      manual_reset_out <= 1'b0;
      capture_en       <= 1'b0;
      readout_req      <= 1'b0;
      busy             <= 1'b0;
    end else begin
      armed_out        <= (next_state == S_ARMED);
      manual_reset_out <= (next_state == S_COMP_RST);
      capture_en       <= (next_state == S_ARMED) || (next_state == S_POST);
      readout_req      <= (next_state == S_READOUT);
      busy             <= (next_state != S_IDLE);
    end
  end

  assign state_out = state;

`ifdef TRIG_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timeout_len_q;
  logic                 tmo_load, tmo_zero, tmo_one;
  logic [TIMEOUT_W-1:0] tmo_val;

  // Timeout restarts on every entry to ARMED; a zero length never fires.
  assign tmo_load     = (next_state == S_ARMED) && (state != S_ARMED);
  assign tmo_val      = (state == S_IDLE) ? timeout_len : timeout_len_q;
  assign timeout_fire = (state == S_ARMED) && tmo_one;

  seq_down_counter #(.W(TIMEOUT_W)) u_tmo (
    .clk      (clk),
    .rst_n    (module_reset_n),
    .load     (tmo_load),
    .en       ((state == S_ARMED) && !tmo_zero),
    .load_val (tmo_val),
    .zero     (tmo_zero),
    .one      (tmo_one)
  );

  // Timeout length latch and timed_out flag; a real trigger wins a tie.
  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n) begin
      timeout_len_q <= '0;
      timed_out     <= 1'b0;
    end else begin
      if (latch_lens) timeout_len_q <= timeout_len;
      if ((state == S_ARMED) && !disarm) begin
        if (real_trig)         timed_out <= 1'b0;
        else if (timeout_fire) timed_out <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_len;
  assign unused_timeout_len = ^timeout_len;
  assign timeout_fire       = 1'b0;
  assign timed_out          = 1'b0;
`endif

endmodule
